// File: rtl/reg8_write_arbiter_pkg.sv
// Shared definitions for the round-robin write arbiter and its helper block.
package reg8_write_arbiter_pkg;

   localparam int DEF_N = 4;
   localparam int DEF_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   // Increment v and wrap back to zero once it reaches n.
   function automatic int wrap_inc(input int v, input int n);
      int r;
      r = v + 1;
      if (r >= n) begin
         r = 0;
      end
      return r;
   endfunction

endpackage

// File: rtl/reg8_write_arbiter_rr_pick.sv
// Combinational round-robin picker: rotates req so ptr sits at bit 0,
// takes the lowest set bit, then rotates the index back.
module rr_pick
   import reg8_write_arbiter_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   logic [N-1:0] rot;
   int           j;
   int           k;

   // Rotate, priority-encode from the bottom, un-rotate.
   always_comb begin
      rot = '0;
      j   = 0;
      k   = 0;
      any = 1'b0;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         j = i + int'(ptr);
         if (j >= N) begin
            j = j - N;
         end
         rot[i] = req[j];
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            k = i;
         end
      end
      any = |rot;
      j = k + int'(ptr);
      if (j >= N) begin
         j = j - N;
      end
      idx = IW'(j);
   end

endmodule

// File: rtl/reg8_write_arbiter.sv
// Round-robin write controller for a shared W-bit holding register.
// One write per three cycles: IDLE picks a winner, LOAD grants and captures
// its data, ACK pulses the done strobe and advances the rotation pointer.
module reg8_write_arbiter
   import reg8_write_arbiter_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic                  clk,
   input  logic                  clear,
   input  logic [N-1:0]          req,
   input  logic [N*W-1:0]        din,
   output logic [N-1:0]          gnt,
   output logic [N-1:0]          ack,
   output logic [W-1:0]          q,
   output logic [$clog2(N)-1:0]  owner,
   output logic                  busy
);

   localparam int IW = $clog2(N);

   state_e        state_q, state_d;
   logic [IW-1:0] sel_q, sel_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [W-1:0]  q_q, q_d;

   logic          pick_any;
   logic [IW-1:0] pick_idx;
   logic [W-1:0]  sel_din;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req (req),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Select the data lane of the currently granted requester.
   always_comb begin
      sel_din = '0;
      for (int i = 0; i < N; i++) begin
         if (IW'(i) == sel_q) begin
            sel_din = din[i*W +: W];
         end
      end
   end

   // Next-state logic for the FSM, winner capture, pointer and register.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      q_d     = q_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               sel_d   = pick_idx;
               owner_d = pick_idx;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            q_d     = sel_din;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            ptr_d   = IW'(wrap_inc(int'(sel_q), N));
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grant and ack strobes decode purely from state so they never overlap.
   always_comb begin
      gnt  = '0;
      ack  = '0;
      busy = (state_q != ST_IDLE);
      if (state_q == ST_LOAD) begin
         gnt[sel_q] = 1'b1;
      end
      if (state_q == ST_ACK) begin
         ack[sel_q] = 1'b1;
      end
   end

   // State registers; clear aborts any in-flight write.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         q_q     <= q_d;
      end
   end

   assign q     = q_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Directed self-checking bench for reg8_write_arbiter with N=4, W=8.
module tb_reg8_write_arbiter;

   logic        clk;
   logic        clear;
   logic [3:0]  req;
   logic [31:0] din;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic [7:0]  q;
   logic [1:0]  owner;
   logic        busy;

   int checks;
   int errors;

   reg8_write_arbiter #(
      .N (4),
      .W (8)
   ) dut (
      .clk   (clk),
      .clear (clear),
      .req   (req),
      .din   (din),
      .gnt   (gnt),
      .ack   (ack),
      .q     (q),
      .owner (owner),
      .busy  (busy)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      req   = '0;
      din   = '0;
      step();
      step();
      clear = 1'b0;
      checks++;
      if (q !== 8'h00 || gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset got q=%h gnt=%b ack=%b busy=%b owner=%0d expected q=00 gnt=0000 ack=0000 busy=0 owner=0",
                  q, gnt, ack, busy, owner);
      end
   endtask

   task automatic test_single();
      din[2*8 +: 8] = 8'hA5;
      req = 4'b0100;
      step();
      checks++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_gnt got gnt=%b busy=%b expected gnt=0100 busy=1", gnt, busy);
      end
      step();
      checks++;
      if (q !== 8'hA5 || ack !== 4'b0100 || gnt !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL single_ack got q=%h ack=%b gnt=%b expected q=a5 ack=0100 gnt=0000", q, ack, gnt);
      end
      req = 4'b0000;
      step();
      checks++;
      if (busy !== 1'b0 || owner !== 2'd2 || q !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL single_done got busy=%b owner=%0d q=%h expected busy=0 owner=2 q=a5", busy, owner, q);
      end
   endtask

   task automatic test_reset_mid_load();
      din[1*8 +: 8] = 8'h77;
      req = 4'b0010;
      step();
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL midload_gnt got %b expected 0010", gnt);
      end
      clear = 1'b1;
      req   = 4'b0000;
      step();
      clear = 1'b0;
      checks++;
      if (q !== 8'h00 || gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
         errors++;
         $display("[TB] FAIL midload_clear got q=%h gnt=%b ack=%b busy=%b owner=%0d expected q=00 gnt=0000 ack=0000 busy=0 owner=0",
                  q, gnt, ack, busy, owner);
      end
      step();
      checks++;
      if (ack !== 4'b0000 || q !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midload_noack got ack=%b q=%h busy=%b expected ack=0000 q=00 busy=0", ack, q, busy);
      end
   endtask

   task automatic test_contention();
      logic [1:0] order [5];
      logic [7:0] exp_q;
      logic [3:0] exp_bit;
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
      din = {8'h13, 8'h12, 8'h11, 8'h10};
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         exp_bit = 4'b0001 << order[n];
         exp_q   = 8'h10 + 8'(order[n]);
         step();
         checks++;
         if (gnt !== exp_bit || owner !== order[n]) begin
            errors++;
            $display("[TB] FAIL contention_gnt[%0d] got gnt=%b owner=%0d expected gnt=%b owner=%0d",
                     n, gnt, owner, exp_bit, order[n]);
         end
         step();
         checks++;
         if (ack !== exp_bit || q !== exp_q) begin
            errors++;
            $display("[TB] FAIL contention_ack[%0d] got ack=%b q=%h expected ack=%b q=%h", n, ack, q, exp_bit, exp_q);
         end
         req = req & ~exp_bit;
         step();
         checks++;
         if (busy !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL contention_idle[%0d] got busy=%b gnt=%b ack=%b expected busy=0 gnt=0000 ack=0000",
                     n, busy, gnt, ack);
         end
         req = req | exp_bit;
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_wrap();
      din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      req = 4'b1000;
      step();
      step();
      req = 4'b0000;
      step();
      checks++;
      if (q !== 8'hD3 || owner !== 2'd3 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wrap_serve3 got q=%h owner=%0d busy=%b expected q=d3 owner=3 busy=0", q, owner, busy);
      end
      req = 4'b1010;
      step();
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL wrap_ptr0 got gnt=%b expected 0010", gnt);
      end
      step();
      req = 4'b0000;
      step();
      req = 4'b0011;
      step();
      checks++;
      if (gnt !== 4'b0001 || owner !== 2'd0) begin
         errors++;
         $display("[TB] FAIL wrap_ptr2 got gnt=%b owner=%0d expected gnt=0001 owner=0", gnt, owner);
      end
      step();
      checks++;
      if (q !== 8'hA0 || ack !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL wrap_ptr2_ack got q=%h ack=%b expected q=a0 ack=0001", q, ack);
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_late_and_drop();
      din = {8'h4D, 8'h3C, 8'h2B, 8'h1A};
      req = 4'b0001;
      step();
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL late_gnt0 got %b expected 0001", gnt);
      end
      step();
      req = 4'b0010;
      step();
      checks++;
      if (busy !== 1'b0 || gnt !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL late_ignored got busy=%b gnt=%b expected busy=0 gnt=0000", busy, gnt);
      end
      step();
      checks++;
      if (gnt !== 4'b0010 || owner !== 2'd1) begin
         errors++;
         $display("[TB] FAIL late_gnt1 got gnt=%b owner=%0d expected gnt=0010 owner=1", gnt, owner);
      end
      step();
      checks++;
      if (ack !== 4'b0010 || q !== 8'h2B) begin
         errors++;
         $display("[TB] FAIL late_ack1 got ack=%b q=%h expected ack=0010 q=2b", ack, q);
      end
      req = 4'b0000;
      step();
      req = 4'b1000;
      step();
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL drop_gnt3 got %b expected 1000", gnt);
      end
      req = 4'b0000;
      step();
      checks++;
      if (ack !== 4'b1000 || q !== 8'h4D) begin
         errors++;
         $display("[TB] FAIL drop_ack3 got ack=%b q=%h expected ack=1000 q=4d", ack, q);
      end
      step();
      checks++;
      if (busy !== 1'b0 || owner !== 2'd3) begin
         errors++;
         $display("[TB] FAIL drop_done got busy=%b owner=%0d expected busy=0 owner=3", busy, owner);
      end
   endtask

   task automatic test_hold();
      logic [7:0] held;
      held = 8'h4D;
      req  = 4'b0000;
      for (int n = 0; n < 20; n++) begin
         din = $urandom;
         step();
         checks++;
         if (q !== held || gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold[%0d] got q=%h gnt=%b ack=%b busy=%b expected q=%h gnt=0000 ack=0000 busy=0",
                     n, q, gnt, ack, busy, held);
         end
      end
   endtask

   // Scenario sequence; each task leaves the DUT idle for the next.
   initial begin
      checks = 0;
      errors = 0;
      clear  = 1'b0;
      req    = '0;
      din    = '0;
      test_reset();
      test_single();
      test_reset_mid_load();
      test_contention();
      test_wrap();
      test_late_and_drop();
      test_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
